// File: rtl/bf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bf_pkg : opcode constants and state encoding for the Brainfuck sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
package bf_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;
  localparam logic [7:0] OP_JZ    = 8'h5B;
  localparam logic [7:0] OP_JNZ   = 8'h5D;
  localparam logic [7:0] OP_END   = 8'h00;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_OUT_WAIT  = 3'd3,
    ST_IN_WAIT   = 3'd4,
    ST_SCAN_FWD  = 3'd5,
    ST_SCAN_BACK = 3'd6,
    ST_HALT      = 3'd7
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bf_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bf_sequencer : Brainfuck control FSM - fetch/decode, tape access, I/O
//                handshakes and bracket matching by scanning.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bf_sequencer
  import bf_pkg::*;
#(
  parameter int PC_WIDTH    = 10,
  parameter int DP_WIDTH    = 8,
  parameter int DEPTH_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] prog_addr,
  input  logic [7:0]          prog_data,
  output logic [DP_WIDTH-1:0] data_addr,
  input  logic [7:0]          data_rdata,
  output logic [7:0]          data_wdata,
  output logic                data_we,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                halted,
  output logic                error
);

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [DP_WIDTH-1:0]    dp_q, dp_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic [7:0]             op_q, op_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   error_q, error_d;
  logic                   scan_smp_q, scan_smp_d;

  logic [PC_WIDTH-1:0]    w_pc_inc, w_pc_dec;
  logic                   w_pc_last, w_pc_zero, w_depth_full, w_depth_one;
  logic                   w_fault;

  assign w_pc_inc     = pc_q + PC_WIDTH'(1);
  assign w_pc_dec     = pc_q - PC_WIDTH'(1);
  assign w_pc_last    = &pc_q;
  assign w_pc_zero    = (pc_q == '0);
  assign w_depth_full = &depth_q;
  assign w_depth_one  = (depth_q == DEPTH_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= '0;
      dp_q       <= '0;
      depth_q    <= '0;
      op_q       <= 8'h00;
      out_data_q <= 8'h00;
      error_q    <= 1'b0;
      scan_smp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dp_q       <= dp_d;
      depth_q    <= depth_d;
      op_q       <= op_d;
      out_data_q <= out_data_d;
      error_q    <= error_d;
      scan_smp_q <= scan_smp_d;
    end
  end

  // Any pc step that would leave the ROM raises w_fault; it overrides state last.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dp_d       = dp_q;
    depth_d    = depth_q;
    op_d       = op_q;
    out_data_d = out_data_q;
    error_d    = error_q;
    scan_smp_d = 1'b0;
    w_fault    = 1'b0;
    unique case (state_q)
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        op_d = prog_data;
        case (prog_data)
          OP_INC, OP_DEC, OP_OUT, OP_JZ, OP_JNZ: state_d = ST_EXEC;
          OP_IN:  state_d = ST_IN_WAIT;
          OP_END: state_d = ST_HALT;
          default: begin
            if (prog_data == OP_RIGHT) dp_d = dp_q + DP_WIDTH'(1);
            if (prog_data == OP_LEFT)  dp_d = dp_q - DP_WIDTH'(1);
            pc_d    = w_pc_inc;
            w_fault = w_pc_last;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        if (op_q == OP_OUT) begin
          out_data_d = data_rdata;
          state_d    = ST_OUT_WAIT;
        end else if (op_q == OP_JNZ && data_rdata != 8'h00) begin
          pc_d    = w_pc_dec;
          w_fault = w_pc_zero;
          depth_d = DEPTH_WIDTH'(1);
          state_d = ST_SCAN_BACK;
        end else begin
          pc_d    = w_pc_inc;
          w_fault = w_pc_last;
          state_d = ST_FETCH;
          if (op_q == OP_JZ && data_rdata == 8'h00) begin
            depth_d = DEPTH_WIDTH'(1);
            state_d = ST_SCAN_FWD;
          end
        end
      end
      ST_OUT_WAIT: if (out_ready) begin
        pc_d    = w_pc_inc;
        w_fault = w_pc_last;
        state_d = ST_FETCH;
      end
      ST_IN_WAIT: if (in_valid) begin
        pc_d    = w_pc_inc;
        w_fault = w_pc_last;
        state_d = ST_FETCH;
      end
      ST_SCAN_FWD: begin
        if (!scan_smp_q) begin
          scan_smp_d = 1'b1;
        end else begin
          pc_d    = w_pc_inc;
          w_fault = w_pc_last || (prog_data == OP_END) ||
                    (prog_data == OP_JZ && w_depth_full);
          if (prog_data == OP_JZ) depth_d = depth_q + DEPTH_WIDTH'(1);
          if (prog_data == OP_JNZ) begin
            depth_d = depth_q - DEPTH_WIDTH'(1);
            if (w_depth_one) state_d = ST_FETCH;
          end
        end
      end
      ST_SCAN_BACK: begin
        if (!scan_smp_q) begin
          scan_smp_d = 1'b1;
        end else if (prog_data == OP_JZ && w_depth_one) begin
          depth_d = '0;
          pc_d    = w_pc_inc;
          w_fault = w_pc_last;
          state_d = ST_FETCH;
        end else begin
          pc_d    = w_pc_dec;
          w_fault = w_pc_zero || (prog_data == OP_END) ||
                    (prog_data == OP_JNZ && w_depth_full);
          if (prog_data == OP_JNZ) depth_d = depth_q + DEPTH_WIDTH'(1);
          if (prog_data == OP_JZ)  depth_d = depth_q - DEPTH_WIDTH'(1);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
    if (w_fault) begin
      state_d = ST_HALT;
      error_d = 1'b1;
    end
  end

  always_comb begin
    data_we    = 1'b0;
    data_wdata = 8'h00;
    if (state_q == ST_EXEC && (op_q == OP_INC || op_q == OP_DEC)) begin
      data_we    = 1'b1;
      data_wdata = (op_q == OP_INC) ? data_rdata + 8'd1 : data_rdata - 8'd1;
    end else if (state_q == ST_IN_WAIT && in_valid) begin
      data_we    = 1'b1;
      data_wdata = in_data;
    end
    out_valid = (state_q == ST_OUT_WAIT);
    in_ready  = (state_q == ST_IN_WAIT);
    halted    = (state_q == ST_HALT);
    error     = error_q;
    out_data  = out_data_q;
    prog_addr = pc_q;
    data_addr = dp_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_bf_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bf_sequencer : directed programs with a scoreboard on the output port.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bf_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] data_addr;
  logic [7:0] data_rdata;
  logic [7:0] data_wdata;
  logic       data_we;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       halted;
  logic       error;

  logic [7:0] rom  [1024];
  logic [7:0] tape [256];

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] exp_q [$];
  int         we_log [$];
  logic       hold = 1'b0;
  logic [7:0] hold_data = 8'h00;

  bf_sequencer dut (
    .clk(clk), .reset(reset),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .data_addr(data_addr), .data_rdata(data_rdata),
    .data_wdata(data_wdata), .data_we(data_we),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prog_data <= rom[prog_addr];
    data_rdata <= tape[data_addr];
    if (data_we) tape[data_addr] <= data_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("out stall valid", {31'd0, out_valid}, 32'd1);
        check("out stall data", {24'd0, out_data}, {24'd0, hold_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out unexpected byte", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          check("out byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        end
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
      if (data_we) we_log.push_back(cyc);
    end
  end

  task automatic do_reset(input string prog);
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    foreach (rom[i]) rom[i] = 8'h00;
    foreach (tape[i]) tape[i] = 8'h00;
    for (int i = 0; i < prog.len(); i++) rom[i] = prog[i];
    exp_q.delete();
    we_log.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst prog_addr", {22'd0, prog_addr}, 32'd0);
    check("rst data_addr", {24'd0, data_addr}, 32'd0);
    check("rst outs", {26'd0, data_we, out_valid, in_ready, halted, error, 1'b0}, 32'd0);
    check("rst data", {16'd0, out_data, data_wdata}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input logic exp_err);
    int n = 0;
    while (!halted && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " halted"}, {31'd0, halted}, 32'd1);
    check({name, " error"}, {31'd0, error}, {31'd0, exp_err});
    check({name, " scoreboard drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " out_valid seen"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    // 1: three increments then output
    do_reset("+++.");
    out_ready = 1'b1;
    exp_q.push_back(8'h03);
    run_to_halt("t1", 1'b0);
    check("t1 write count", we_log.size(), 32'd3);
    if (we_log.size() == 3) begin
      check("t1 '+' period a", we_log[1] - we_log[0], 32'd3);
      check("t1 '+' period b", we_log[2] - we_log[1], 32'd3);
    end

    // 2: loop moves cell0 into cell1
    do_reset("++[>+<-]>.");
    out_ready = 1'b1;
    exp_q.push_back(8'h02);
    run_to_halt("t2", 1'b0);
    check("t2 cell0", {24'd0, tape[0]}, 32'h00);
    check("t2 cell1", {24'd0, tape[1]}, 32'h02);

    // 3: forward scan over a nested loop
    do_reset("[+[+]+].");
    out_ready = 1'b1;
    exp_q.push_back(8'h00);
    run_to_halt("t3", 1'b0);
    check("t3 no writes", we_log.size(), 32'd0);

    // 4: delayed input, stalled output
    do_reset(",.");
    exp_q.push_back(8'h41);
    begin
      int n = 0;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("t4 in_ready held", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_data = 8'h41;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 8'h00;
    check("t4 in_ready dropped", {31'd0, in_ready}, 32'd0);
    wait_out_valid("t4");
    repeat (4) @(posedge clk);
    #1;
    check("t4 out held", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h41});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t4 out_valid dropped", {31'd0, out_valid}, 32'd0);
    run_to_halt("t4", 1'b0);
    check("t4 cell0", {24'd0, tape[0]}, 32'h41);

    // 5: dp wraps below zero
    do_reset("<-.");
    out_ready = 1'b1;
    exp_q.push_back(8'hFF);
    run_to_halt("t5", 1'b0);
    check("t5 cell255", {24'd0, tape[255]}, 32'hFF);
    check("t5 cell0", {24'd0, tape[0]}, 32'h00);

    // 6: unmatched ']' scans back past pc 0
    do_reset("+]");
    out_ready = 1'b1;
    run_to_halt("t6", 1'b1);

    // 7: reset while waiting on output, then restart with tape kept
    do_reset("+.");
    wait_out_valid("t7");
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("t7 out_valid on reset", {31'd0, out_valid}, 32'd0);
    check("t7 pc on reset", {22'd0, prog_addr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(8'h02);
    run_to_halt("t7", 1'b0);
    check("t7 cell0", {24'd0, tape[0]}, 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
